// File: rtl/rms_pkg.sv
// Shared defaults and the reader state type for the windowed sample reader.
package rms_pkg;

    localparam int SAMP_W_DEF   = 16;
    localparam int WIN_LOG2_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sq_unit.sv
// Combinational signed square. A SAMP_W-bit signed input squares to a
// non-negative value that always fits in 2*SAMP_W bits, including the most
// negative input, which yields 2^(2*SAMP_W-2).
module sq_unit
    import rms_pkg::*;
#(
    parameter int SAMP_W = SAMP_W_DEF
) (
    input  logic [SAMP_W-1:0]   samp,
    output logic [2*SAMP_W-1:0] sq
);

    logic signed [2*SAMP_W-1:0] ext;

    // Sign-extend to full width first so the product is computed at 2*SAMP_W bits.
    always_comb begin
        ext = {{SAMP_W{samp[SAMP_W-1]}}, samp};
        sq  = $unsigned(ext * ext);
    end

endmodule

// File: rtl/sample_reader.sv
// Windowed mean-of-squares reader fed by a first-word-fall-through FIFO.
// Pops one sample per cycle while enabled, accumulates squares over a window
// of 2^WIN_LOG2 samples, then presents mean_sq (and peak) until handshaken.
// Optional feature: define SAMPLE_READER_PEAK_EN to track max |sample| per
// window; without it, peak is tied to zero.
module sample_reader
    import rms_pkg::*;
#(
    parameter int SAMP_W   = SAMP_W_DEF,
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           data_in,
    input  logic                  empty,
    output logic                  rd_en,
    input  logic                  en,
    input  logic                  clr,
    output logic [2*SAMP_W-1:0]   mean_sq,
    output logic [SAMP_W-1:0]     peak,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIN_LOG2-1:0]   sample_cnt
);

    localparam int ACC_W = 2*SAMP_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);

    rd_state_e           state, state_nxt;
    logic [SAMP_W-1:0]   samp;
    logic [2*SAMP_W-1:0] sq;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic                pop;
    logic                win_last;
    logic                hs;

    assign samp = data_in[SAMP_W-1:0];

    generate
        if (SAMP_W < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^data_in[31:SAMP_W];
        end
    endgenerate

    sq_unit #(.SAMP_W(SAMP_W)) u_sq (
        .samp (samp),
        .sq   (sq)
    );

    assign acc_sum = acc + {{WIN_LOG2{1'b0}}, sq};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and pop strobe; clr overrides every transition and blocks pops.
    always_comb begin
        state_nxt = state;
        rd_en     = (state == ACCUM) & en & ~empty & ~clr;
        pop       = rd_en;
        win_last  = rd_en & (&sample_cnt);
        hs        = (state == HOLD) & out_valid & out_ready;
        case (state)
            IDLE:    if (en) state_nxt = ACCUM;
            ACCUM: begin
                if (win_last) state_nxt = HOLD;
                else if (!en) state_nxt = IDLE;
            end
            HOLD:    if (hs) state_nxt = en ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clr) state_nxt = IDLE;
    end

    // Accumulator, window counter and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            sample_cnt <= '0;
            mean_sq    <= '0;
            out_valid  <= 1'b0;
        end else if (clr) begin
            // Abort the window but keep the last published result.
            acc        <= '0;
            sample_cnt <= '0;
            out_valid  <= 1'b0;
        end else begin
            if (pop) begin
                if (win_last) begin
                    mean_sq    <= acc_sum[ACC_W-1:WIN_LOG2];
                    out_valid  <= 1'b1;
                    acc        <= '0;
                    sample_cnt <= '0;
                end else begin
                    acc        <= acc_sum;
                    sample_cnt <= sample_cnt + CNT_ONE;
                end
            end
            if (hs) out_valid <= 1'b0;
        end
    end

`ifdef SAMPLE_READER_PEAK_EN
    localparam logic [SAMP_W-1:0] S_MIN = {1'b1, {(SAMP_W-1){1'b0}}};
    localparam logic [SAMP_W-1:0] S_MAX = {1'b0, {(SAMP_W-1){1'b1}}};
    localparam logic [SAMP_W-1:0] S_ONE = SAMP_W'(1);

    logic [SAMP_W-1:0] mag;
    logic [SAMP_W-1:0] peak_trk;
    logic [SAMP_W-1:0] peak_nxt;

    // Saturating magnitude and running maximum including the current sample.
    always_comb begin
        mag = samp;
        if (samp[SAMP_W-1]) mag = (samp == S_MIN) ? S_MAX : (~samp + S_ONE);
        peak_nxt = (mag > peak_trk) ? mag : peak_trk;
    end

    // Peak tracker per window, published together with mean_sq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_trk <= '0;
            peak     <= '0;
        end else if (clr) begin
            peak_trk <= '0;
        end else if (pop) begin
            if (win_last) begin
                peak     <= peak_nxt;
                peak_trk <= '0;
            end else begin
                peak_trk <= peak_nxt;
            end
        end
    end
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader with a small FWFT FIFO model.
module tb_sample_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        empty = 1'b1;
    logic        rd_en;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] mean_sq;
    logic [15:0] peak;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  sample_cnt;

`ifdef SAMPLE_READER_PEAK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic [31:0] fifo[$];
    int pop_cnt  = 0;
    int viol_cnt = 0;
    int n_chk    = 0;
    int n_fail   = 0;

    sample_reader #(.SAMP_W(16), .WIN_LOG2(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .empty      (empty),
        .rd_en      (rd_en),
        .en         (en),
        .clr        (clr),
        .mean_sq    (mean_sq),
        .peak       (peak),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    // FIFO pop on the clock edge the DUT consumes the head.
    always @(posedge clk) begin
        if (rd_en) begin
            if (empty) viol_cnt++;
            pop_cnt++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
    end

    // Present the FIFO head away from the active edge.
    always @(negedge clk) begin
        empty   = (fifo.size() == 0);
        data_in = empty ? 32'h0 : fifo[0];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int n, input logic [31:0] v);
        for (int i = 0; i < n; i++) fifo.push_back(v);
    endtask

    task automatic wait_pops(input int target, input string tag);
        int n = 0;
        while (pop_cnt < target && n < 300) begin
            tick();
            n++;
        end
        if (pop_cnt < target) chk({tag, "_timeout"}, 64'(pop_cnt), 64'(target));
    endtask

    int base;
    bit bad;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_mean", mean_sq, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_peak", peak, 0);
        chk("rst_rden", rd_en, 0);
        rst_n = 1'b1;
        tick();

        // 16 x 3 -> mean 9, peak 3, valid one cycle after the last pop
        base = pop_cnt;
        en = 1'b1;
        out_ready = 1'b1;
        push(16, 32'h0003);
        wait_pops(base + 16, "t1");
        chk("t1_valid", out_valid, 1);
        chk("t1_mean", mean_sq, 9);
        chk("t1_peak", peak, PEAK_ON ? 3 : 0);
        tick();
        chk("t1_valid_1cyc", out_valid, 0);
        tick();
        tick();
        chk("t1_pops", 64'(pop_cnt - base), 16);

        // 16 x -4 -> mean 16, peak 4
        base = pop_cnt;
        push(16, 32'h0000_FFFC);
        wait_pops(base + 16, "t2");
        chk("t2_valid", out_valid, 1);
        chk("t2_mean", mean_sq, 16);
        chk("t2_peak", peak, PEAK_ON ? 4 : 0);
        tick();

        // 8 x 0 then 8 x 0x100 -> mean 0x8000
        base = pop_cnt;
        push(8, 32'h0);
        push(8, 32'h0100);
        wait_pops(base + 16, "t3");
        chk("t3_mean", mean_sq, 32'h8000);
        chk("t3_peak", peak, PEAK_ON ? 16'h0100 : 0);
        tick();

        // Backpressure: result held, no pops while out_ready=0
        base = pop_cnt;
        out_ready = 1'b0;
        push(20, 32'h0005);
        wait_pops(base + 16, "t4");
        chk("t4_valid", out_valid, 1);
        chk("t4_mean", mean_sq, 25);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (rd_en !== 1'b0 || out_valid !== 1'b1 || mean_sq !== 32'd25 || pop_cnt != base + 16)
                bad = 1'b1;
        end
        chk("t4_hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        chk("t4_hs_clear", out_valid, 0);
        chk("t4_hs_nopop", 64'(pop_cnt - base), 16);
        chk("t4_resume_rden", rd_en, 1);
        tick();
        chk("t4_resume_pop", 64'(pop_cnt - base), 17);
        wait_pops(base + 20, "t4b");
        chk("t4_cnt4", sample_cnt, 4);

        // Abort after 7 pops; last result must survive
        push(3, 32'h0005);
        wait_pops(base + 23, "t4c");
        chk("t4_cnt7", sample_cnt, 7);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_cnt", sample_cnt, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_mean_kept", mean_sq, 25);
        chk("clr_peak_kept", peak, PEAK_ON ? 5 : 0);

        // 16 x 2 with an en=0 gap mid-window -> mean 4, no residue
        base = pop_cnt;
        push(8, 32'h0002);
        wait_pops(base + 8, "t5");
        chk("t5_cnt8", sample_cnt, 8);
        en = 1'b0;
        push(8, 32'h0002);
        repeat (4) tick();
        chk("t5_gap_nopop", 64'(pop_cnt - base), 8);
        chk("t5_gap_cnt", sample_cnt, 8);
        en = 1'b1;
        wait_pops(base + 16, "t5b");
        chk("t5_valid", out_valid, 1);
        chk("t5_mean", mean_sq, 4);
        chk("t5_peak", peak, PEAK_ON ? 2 : 0);
        tick();

        // Most negative sample: square 2^30, magnitude saturates
        base = pop_cnt;
        push(16, 32'h0000_8000);
        wait_pops(base + 16, "t6");
        chk("t6_mean", mean_sq, 32'h4000_0000);
        chk("t6_peak", peak, PEAK_ON ? 16'h7FFF : 0);
        tick();

        // Async reset while a result is held
        base = pop_cnt;
        out_ready = 1'b0;
        push(18, 32'h0003);
        wait_pops(base + 16, "t7");
        chk("t7_valid_pre", out_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", out_valid, 0);
        chk("t7_rst_mean", mean_sq, 0);
        chk("t7_rst_cnt", sample_cnt, 0);
        chk("t7_rst_rden", rd_en, 0);
        fifo.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("no_pop_when_empty", 64'(viol_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
